// File: rtl/eth_tx_pkt_gen_pkg.sv
// Shared types and constants for the ethernet TX packet generator:
// FSM encoding, payload pattern modes and the payload LFSR step.
package eth_tx_pkt_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_WR,
    ST_HDR,
    ST_PAY,
    ST_WAIT_SEND,
    ST_SEND,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

  localparam logic [1:0] PAT_CONST = 2'd0;
  localparam logic [1:0] PAT_INC   = 2'd1;
  localparam logic [1:0] PAT_LFSR  = 2'd2;
  localparam logic [1:0] PAT_SEQ   = 2'd3;

  localparam int LFSR_W = 32;
  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/eth_tx_pkt_gen_if.sv
// Word-wide TX handshake towards ethernet_module; the generator is the master.
interface eth_tx_pkt_gen_if #(
  parameter int WORD_W = 32
);
  logic              tx_valid;
  logic [WORD_W-1:0] tx_data_in;
  logic              tx_send;
  logic              tx_ready_to_write;
  logic              tx_ready_to_send;
  logic              tx_done;

  modport master (
    output tx_valid, tx_data_in, tx_send,
    input  tx_ready_to_write, tx_ready_to_send, tx_done
  );

  modport slave (
    input  tx_valid, tx_data_in, tx_send,
    output tx_ready_to_write, tx_ready_to_send, tx_done
  );
endinterface

// File: rtl/eth_tx_pkt_gen_pattern.sv
// Payload word source: load restarts the pattern for a new packet, step
// advances to the next word; word_o always shows the current word.
module eth_tx_pkt_gen_pattern
  import eth_tx_pkt_gen_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_100_mhz,
  input  logic              rst,
  input  logic [1:0]        mode_i,
  input  logic [WORD_W-1:0] seed_i,
  input  logic [CNT_W-1:0]  seq_no_i,
  input  logic              load_i,
  input  logic              step_i,
  output logic [WORD_W-1:0] word_o
);

  localparam int HALF = WORD_W / 2;

  logic [LFSR_W-1:0] lfsr_q;
  logic [WORD_W-1:0] idx_q;
  logic [LFSR_W-1:0] seed_lfsr;
  logic [HALF-1:0]   seq_h;

  assign seed_lfsr = LFSR_W'(seed_i);
  assign seq_h     = HALF'(seq_no_i);

  always_ff @(posedge clk_100_mhz or posedge rst) begin
    if (rst) begin
      lfsr_q <= '0;
      idx_q  <= '0;
    end else if (load_i) begin
      // An all-zero LFSR would lock up, so a zero seed starts from 1.
      lfsr_q <= (seed_lfsr == '0) ? LFSR_W'(1) : seed_lfsr;
      idx_q  <= '0;
    end else if (step_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
      idx_q  <= idx_q + WORD_W'(1);
    end
  end

  always_comb begin
    word_o = seed_i;
    case (mode_i)
      PAT_CONST: word_o = seed_i;
      PAT_INC:   word_o = seed_i + idx_q;
      PAT_LFSR:  word_o = WORD_W'(lfsr_q);
      PAT_SEQ:   word_o = {seq_h, idx_q[HALF-1:0]};
      default:   word_o = seed_i;
    endcase
  end

endmodule

// File: rtl/eth_tx_pkt_gen.sv
// Packet generator feeding ethernet_module's word-wide TX port: header from
// a port, pattern payload, programmable length/repeat/gap and tx_done timeout.
module eth_tx_pkt_gen
  import eth_tx_pkt_gen_pkg::*;
#(
  parameter int WORD_W       = 32,
  parameter int HDR_WORDS    = 6,
  parameter int LEN_W        = 8,
  parameter int CNT_W        = 16,
  parameter int GAP_W        = 24,
  parameter int DONE_TIMEOUT = 2000000
) (
  input  logic                        clk_100_mhz,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [HDR_WORDS*WORD_W-1:0] hdr,
  input  logic [LEN_W-1:0]            payload_len,
  input  logic [1:0]                  pattern_mode,
  input  logic [WORD_W-1:0]           pattern_seed,
  input  logic [CNT_W-1:0]            pkt_count,
  input  logic [GAP_W-1:0]            gap_cycles,
  eth_tx_pkt_gen_if.master            tx,
  output logic                        busy,
  output logic                        done,
  output logic                        err_timeout,
  output logic [CNT_W-1:0]            pkts_sent
);

  localparam int HDR_CW = $clog2(HDR_WORDS + 1);
  localparam int IDX_W  = (HDR_CW > LEN_W) ? HDR_CW : LEN_W;
  localparam int TMR_W  = $clog2(DONE_TIMEOUT + 1);

  state_t                      state_q;
  logic [HDR_WORDS*WORD_W-1:0] cfg_hdr_q;
  logic [LEN_W-1:0]            cfg_len_q;
  logic [1:0]                  cfg_mode_q;
  logic [WORD_W-1:0]           cfg_seed_q;
  logic [CNT_W-1:0]            cfg_count_q;
  logic [GAP_W-1:0]            cfg_gap_q;
  logic [IDX_W-1:0]            idx_q;
  logic [GAP_W-1:0]            gap_cnt_q;
  logic [TMR_W-1:0]            tmr_q;
  logic                        abort_pend_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        err_q;
  logic [CNT_W-1:0]            pkts_sent_q;
  logic                        tx_valid_q;
  logic [WORD_W-1:0]           tx_data_q;
  logic                        tx_send_q;

  logic [WORD_W-1:0] hdr_word [HDR_WORDS];
  logic [WORD_W-1:0] hdr_sel;
  logic [WORD_W-1:0] pat_word;
  logic              hdr_last, pay_last, last_pkt, abort_now;
  logic              pat_load, pat_step;

  for (genvar gi = 0; gi < HDR_WORDS; gi++) begin : g_hdr
    assign hdr_word[gi] = cfg_hdr_q[(HDR_WORDS-1-gi)*WORD_W +: WORD_W];
  end

  always_comb begin
    hdr_sel = '0;
    for (int i = 0; i < HDR_WORDS; i++) begin
      if (idx_q == IDX_W'(i)) hdr_sel = hdr_word[i];
    end
  end

  assign hdr_last  = (idx_q == IDX_W'(HDR_WORDS));
  assign pay_last  = (idx_q == IDX_W'(cfg_len_q));
  assign last_pkt  = (cfg_count_q != '0) && ((pkts_sent_q + CNT_W'(1)) == cfg_count_q);
  assign abort_now = abort_pend_q | abort;
  assign pat_load  = (state_q == ST_WAIT_WR);
  assign pat_step  = ((state_q == ST_HDR) && hdr_last && (cfg_len_q != '0)) ||
                     ((state_q == ST_PAY) && !pay_last);

  eth_tx_pkt_gen_pattern #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_pattern (
    .clk_100_mhz (clk_100_mhz),
    .rst         (rst),
    .mode_i      (cfg_mode_q),
    .seed_i      (cfg_seed_q),
    .seq_no_i    (pkts_sent_q),
    .load_i      (pat_load),
    .step_i      (pat_step),
    .word_o      (pat_word)
  );

  always_ff @(posedge clk_100_mhz or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cfg_hdr_q    <= '0;
      cfg_len_q    <= '0;
      cfg_mode_q   <= '0;
      cfg_seed_q   <= '0;
      cfg_count_q  <= '0;
      cfg_gap_q    <= '0;
      idx_q        <= '0;
      gap_cnt_q    <= '0;
      tmr_q        <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      pkts_sent_q  <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_send_q    <= 1'b0;
    end else begin
      tx_send_q <= 1'b0;
      if (state_q != ST_IDLE && abort) abort_pend_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cfg_hdr_q    <= hdr;
            cfg_len_q    <= payload_len;
            cfg_mode_q   <= pattern_mode;
            cfg_seed_q   <= pattern_seed;
            cfg_count_q  <= pkt_count;
            cfg_gap_q    <= gap_cycles;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            pkts_sent_q  <= '0;
            busy_q       <= 1'b1;
            abort_pend_q <= 1'b0;
            state_q      <= ST_WAIT_WR;
          end
        end
        // Between packets an abort can end the run without starting another.
        ST_WAIT_WR: begin
          if (abort_now) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            abort_pend_q <= 1'b0;
            state_q      <= ST_IDLE;
          end else if (tx.tx_ready_to_write) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= hdr_word[0];
            idx_q      <= IDX_W'(1);
            state_q    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (!hdr_last) begin
            tx_data_q <= hdr_sel;
            idx_q     <= idx_q + IDX_W'(1);
          end else if (cfg_len_q == '0) begin
            tx_valid_q <= 1'b0;
            state_q    <= ST_WAIT_SEND;
          end else begin
            tx_data_q <= pat_word;
            idx_q     <= IDX_W'(1);
            state_q   <= ST_PAY;
          end
        end
        ST_PAY: begin
          if (pay_last) begin
            tx_valid_q <= 1'b0;
            state_q    <= ST_WAIT_SEND;
          end else begin
            tx_data_q <= pat_word;
            idx_q     <= idx_q + IDX_W'(1);
          end
        end
        ST_WAIT_SEND: begin
          if (tx.tx_ready_to_send) begin
            tx_send_q <= 1'b1;
            state_q   <= ST_SEND;
          end
        end
        // The timer starts at 1 so it measures cycles since tx_send rose.
        ST_SEND: begin
          tmr_q   <= TMR_W'(1);
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (tx.tx_done) begin
            pkts_sent_q <= pkts_sent_q + CNT_W'(1);
            if (last_pkt || abort_now) begin
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              abort_pend_q <= 1'b0;
              state_q      <= ST_IDLE;
            end else if (cfg_gap_q == '0) begin
              state_q <= ST_WAIT_WR;
            end else begin
              gap_cnt_q <= GAP_W'(1);
              state_q   <= ST_GAP;
            end
          end else if (tmr_q == TMR_W'(DONE_TIMEOUT - 1)) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b1;
            abort_pend_q <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        ST_GAP: begin
          if (abort_now) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            abort_pend_q <= 1'b0;
            state_q      <= ST_IDLE;
          end else if (gap_cnt_q == cfg_gap_q) begin
            state_q <= ST_WAIT_WR;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx.tx_valid   = tx_valid_q;
  assign tx.tx_data_in = tx_data_q;
  assign tx.tx_send    = tx_send_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_timeout   = err_q;
  assign pkts_sent     = pkts_sent_q;

endmodule

// File: tb/tb_eth_tx_pkt_gen.sv
// Directed bench for eth_tx_pkt_gen with a small ethernet_module stand-in
// (ready_to_send 3 cycles after the last word, tx_done 50 cycles after tx_send).
module tb_eth_tx_pkt_gen;

  localparam int WORD_W    = 32;
  localparam int HDR_WORDS = 6;
  localparam int LEN_W     = 8;
  localparam int CNT_W     = 16;
  localparam int GAP_W     = 24;
  localparam int TMO       = 100;

  logic                        clk_100_mhz = 1'b0;
  logic                        rst = 1'b1;
  logic                        start = 1'b0;
  logic                        abort = 1'b0;
  logic [HDR_WORDS*WORD_W-1:0] hdr = '0;
  logic [LEN_W-1:0]            payload_len = '0;
  logic [1:0]                  pattern_mode = '0;
  logic [WORD_W-1:0]           pattern_seed = '0;
  logic [CNT_W-1:0]            pkt_count = '0;
  logic [GAP_W-1:0]            gap_cycles = '0;
  logic                        busy, done, err_timeout;
  logic [CNT_W-1:0]            pkts_sent;

  eth_tx_pkt_gen_if #(.WORD_W(WORD_W)) bus ();

  eth_tx_pkt_gen #(
    .WORD_W(WORD_W), .HDR_WORDS(HDR_WORDS), .LEN_W(LEN_W),
    .CNT_W(CNT_W), .GAP_W(GAP_W), .DONE_TIMEOUT(TMO)
  ) dut (
    .clk_100_mhz (clk_100_mhz),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .hdr         (hdr),
    .payload_len (payload_len),
    .pattern_mode(pattern_mode),
    .pattern_seed(pattern_seed),
    .pkt_count   (pkt_count),
    .gap_cycles  (gap_cycles),
    .tx          (bus),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .pkts_sent   (pkts_sent)
  );

  always #5 clk_100_mhz = ~clk_100_mhz;

  int cyc = 0;
  always @(posedge clk_100_mhz) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  len;
    logic [1:0]  mode;
    logic [31:0] seed;
    logic [15:0] count;
    logic [23:0] gap;
    bit          pre_abort;
    int          exp_pkts;
    logic [31:0] exp_first;
    bit          chk_last;
    logic [31:0] exp_last;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] wq[$];
  logic [31:0] exp_q[$];
  int          runs[$];
  int          run_start[$];
  int          send_cyc[$];
  int          done_cyc[$];
  bit          no_done = 1'b0;

  function automatic logic [31:0] hw(input int i);
    return 32'hA5A5_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  function automatic void build_exp(input vec_t v);
    logic [31:0] s;
    logic [31:0] w;
    exp_q.delete();
    for (int p = 0; p < v.exp_pkts; p++) begin
      for (int i = 0; i < HDR_WORDS; i++) exp_q.push_back(hw(i));
      s = (v.seed == 32'd0) ? 32'd1 : v.seed;
      for (int i = 0; i < int'(v.len); i++) begin
        case (v.mode)
          2'd0:    w = v.seed;
          2'd1:    w = v.seed + 32'(i);
          2'd2:    begin w = s; s = ref_lfsr(s); end
          default: w = {16'(p), 16'(i)};
        endcase
        exp_q.push_back(w);
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic clear_mon();
    wq.delete(); runs.delete(); run_start.delete();
    send_cyc.delete(); done_cyc.delete();
  endtask

  // ethernet_module stand-in and bus monitor
  initial begin
    int  run_len, rts_wait, done_wait;
    bit  valid_prev;
    run_len = 0; rts_wait = -1; done_wait = -1; valid_prev = 1'b0;
    bus.tx_ready_to_write = 1'b1;
    bus.tx_ready_to_send  = 1'b0;
    bus.tx_done           = 1'b0;
    forever begin
      @(negedge clk_100_mhz);
      bus.tx_done = 1'b0;
      if (rst) begin
        valid_prev = 1'b0; rts_wait = -1; done_wait = -1; run_len = 0;
        bus.tx_ready_to_send = 1'b0;
      end else begin
        if (bus.tx_valid) begin
          wq.push_back(bus.tx_data_in);
          if (!valid_prev) run_start.push_back(cyc);
          run_len++;
        end else if (valid_prev) begin
          runs.push_back(run_len);
          run_len = 0;
          rts_wait = 1;
        end else if (rts_wait > 0) begin
          rts_wait++;
          if (rts_wait == 3) begin
            bus.tx_ready_to_send = 1'b1;
            rts_wait = -1;
          end
        end
        valid_prev = bus.tx_valid;
        if (bus.tx_send) begin
          bus.tx_ready_to_send = 1'b0;
          send_cyc.push_back(cyc);
          done_wait = no_done ? -1 : 0;
        end else if (done_wait >= 0) begin
          done_wait++;
          if (done_wait == 50) begin
            bus.tx_done = 1'b1;
            done_cyc.push_back(cyc);
            done_wait = -1;
          end
        end
      end
    end
  end

  task automatic start_run(input vec_t v);
    @(negedge clk_100_mhz);
    payload_len = v.len; pattern_mode = v.mode; pattern_seed = v.seed;
    pkt_count = v.count; gap_cycles = v.gap;
    if (v.pre_abort) begin
      abort = 1'b1;
      @(negedge clk_100_mhz);
    end
    start = 1'b1;
    abort = v.pre_abort;
    @(negedge clk_100_mhz);
    start = 1'b0;
    abort = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk_100_mhz);
    end
    if (!ok) chk("run_finished", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    bit ok;
    int bad, bad_runs, bad_gap;
    clear_mon();
    build_exp(v);
    start_run(v);
    wait_idle(ok);
    chk("pkts_sent", 32'(pkts_sent), 32'(v.exp_pkts));
    chk("done", 32'(done), 32'd1);
    chk("err_timeout", 32'(err_timeout), 32'd0);
    chk("word_count", 32'(wq.size()), 32'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
      if (wq[i] !== exp_q[i]) bad++;
    chk("word_stream", 32'(bad), 32'd0);
    chk("packets", 32'(runs.size()), 32'(v.exp_pkts));
    chk("sends", 32'(send_cyc.size()), 32'(v.exp_pkts));
    bad_runs = 0;
    foreach (runs[i]) if (runs[i] != HDR_WORDS + int'(v.len)) bad_runs++;
    chk("contiguous", 32'(bad_runs), 32'd0);
    bad_gap = 0;
    for (int p = 1; p < run_start.size() && p <= done_cyc.size(); p++)
      if (run_start[p] - done_cyc[p-1] - 1 < int'(v.gap)) bad_gap++;
    chk("gap", 32'(bad_gap), 32'd0);
    if (v.len != 8'd0) chk("first_payload", wq[HDR_WORDS], v.exp_first);
    if (v.chk_last) chk("last_word", wq[wq.size()-1], v.exp_last);
    $display("vec %0d: len=%0d mode=%0d count=%0d gap=%0d -> words=%0d pkts_sent=%0d done=%0b",
             id, v.len, v.mode, v.count, v.gap, wq.size(), pkts_sent, done);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    bit   ok;
    int   t_err, nv;

    tbl[0] = '{8'd4,   2'd1, 32'h0000_0100, 16'd1, 24'd0,  1'b0, 1, 32'h0000_0100, 1'b1, 32'h0000_0103};
    tbl[1] = '{8'd3,   2'd3, 32'h0000_0005, 16'd3, 24'd20, 1'b1, 3, 32'h0000_0000, 1'b1, 32'h0002_0002};
    tbl[2] = '{8'd0,   2'd2, 32'h0000_0000, 16'd1, 24'd0,  1'b0, 1, 32'h0000_0000, 1'b1, 32'hA5A5_0005};
    tbl[3] = '{8'd255, 2'd2, 32'h0000_0000, 16'd1, 24'd0,  1'b0, 1, 32'h0000_0001, 1'b0, 32'h0000_0000};
    tbl[4] = '{8'd2,   2'd0, 32'hDEAD_BEEF, 16'd2, 24'd3,  1'b0, 2, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    tbl[5] = '{8'd3,   2'd1, 32'hFFFF_FFFE, 16'd1, 24'd0,  1'b0, 1, 32'hFFFF_FFFE, 1'b1, 32'h0000_0000};

    for (int i = 0; i < HDR_WORDS; i++) hdr[(HDR_WORDS-1-i)*WORD_W +: WORD_W] = hw(i);

    repeat (3) @(negedge clk_100_mhz);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_send", 32'(bus.tx_send), 32'd0);
    chk("rst_tx_data", bus.tx_data_in, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_pkts_sent", 32'(pkts_sent), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk_100_mhz);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // tx_done never arrives: the run must give up exactly TMO cycles after tx_send
    no_done = 1'b1;
    clear_mon();
    v = '{8'd2, 2'd1, 32'h10, 16'd1, 24'd0, 1'b0, 1, 32'h10, 1'b0, 32'h0};
    start_run(v);
    wait_idle(ok);
    t_err = cyc;
    chk("tmo_err", 32'(err_timeout), 32'd1);
    chk("tmo_done", 32'(done), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_latency", 32'(t_err - ((send_cyc.size() > 0) ? send_cyc[0] : 0)), 32'(TMO));
    $display("timeout: err_timeout=%0b after %0d cycles", err_timeout, t_err - ((send_cyc.size() > 0) ? send_cyc[0] : 0));
    no_done = 1'b0;

    // endless run, abort during packet 2's payload
    v = '{8'd8, 2'd1, 32'h2000, 16'd0, 24'd5, 1'b0, 2, 32'h2000, 1'b1, 32'h2007};
    clear_mon();
    build_exp(v);
    start_run(v);
    chk("err_cleared_by_start", 32'(err_timeout), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_100_mhz);
      if (wq.size() >= 14 + HDR_WORDS + 3) begin ok = 1'b1; break; end
    end
    if (!ok) chk("abort_reach_pkt2", 32'd0, 32'd1);
    abort = 1'b1;
    @(negedge clk_100_mhz);
    abort = 1'b0;
    wait_idle(ok);
    chk("abort_pkts_sent", 32'(pkts_sent), 32'd2);
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_words", 32'(wq.size()), 32'd28);
    nv = 0;
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++) if (wq[i] !== exp_q[i]) nv++;
    chk("abort_stream", 32'(nv), 32'd0);
    $display("abort: words=%0d pkts_sent=%0d done=%0b", wq.size(), pkts_sent, done);

    // reset while the header is going out, then a clean rerun of the basic case
    clear_mon();
    start_run(tbl[0]);
    nv = 0;
    for (int i = 0; i < 200 && nv < 2; i++) begin
      @(negedge clk_100_mhz);
      if (bus.tx_valid) nv++;
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("midrst_tx_data", bus.tx_data_in, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pkts_sent", 32'(pkts_sent), 32'd0);
    $display("mid-run reset: tx_valid=%0b busy=%0b", bus.tx_valid, busy);
    repeat (2) @(negedge clk_100_mhz);
    rst = 1'b0;
    repeat (2) @(negedge clk_100_mhz);
    run_vec(tbl[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
